// File: rtl/code_verifier_if.sv
// Keypad-side and lock-side signals of code_verifier, bundled with
// master (keypad/stimulus side) and slave (verifier side) views.
interface code_verifier_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       unlocked;
    logic       err_start;
    logic       locked_out;
    logic [2:0] digit_cnt;
    logic [2:0] fail_cnt;

    modport master (
        output key_valid, key_code,
        input  unlocked, err_start, locked_out, digit_cnt, fail_cnt
    );

    modport slave (
        input  key_valid, key_code,
        output unlocked, err_start, locked_out, digit_cnt, fail_cnt
    );
endinterface

// File: rtl/code_verifier.sv
// Six-digit keypad code checker driving the lock, the failure flasher and a lockout timer.
// Optional password change from the open state is enabled by defining PWD_CHANGE_EN.
module code_verifier #(
    parameter logic [23:0] DEFAULT_PWD    = 24'h123456,
    parameter int          MAX_FAIL       = 3,
    parameter int          UNLOCK_CYCLES  = 500,
    parameter int          LOCKOUT_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    code_verifier_if.slave kif
);

    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
    localparam logic [TW-1:0] TIMER_ZERO   = TW'(0);
    localparam logic [2:0]    MAX_FAIL_C   = 3'(MAX_FAIL);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
`ifdef PWD_CHANGE_EN
        ST_SET     = 3'd4,
`endif
        ST_LOCKOUT = 3'd3
    } state_t;

    function automatic logic [23:0] shift_digit(input logic [23:0] b, input logic [3:0] d);
        return {b[19:0], d};
    endfunction

    state_t        state_r, state_s;
    logic [23:0]   entry_buf_r, entry_buf_s;
    logic [2:0]    digit_cnt_r, digit_cnt_s;
    logic [2:0]    fail_cnt_r, fail_cnt_s;
    logic [TW-1:0] timer_r, timer_s;
    logic          match_r, match_s;
    logic          unlocked_r, unlocked_s;
    logic          err_start_r, err_start_s;
    logic          locked_out_r, locked_out_s;
    logic [23:0]   cur_pwd_s;
    logic [23:0]   collect_buf_s;
    logic [2:0]    collect_cnt_s;
    logic [2:0]    fail_inc_s;
    logic          key_digit_s, key_clear_s, key_enter_s;
    logic          timer_last_s;

`ifdef PWD_CHANGE_EN
    logic [23:0]   pwd_r, pwd_next_s;
    logic          key_set_s;
    assign key_set_s = kif.key_valid && (kif.key_code == 4'hC);
    assign cur_pwd_s = pwd_r;
`else
    assign cur_pwd_s = DEFAULT_PWD;
`endif

    assign key_digit_s  = kif.key_valid && (kif.key_code <= 4'd9);
    assign key_clear_s  = kif.key_valid && (kif.key_code == 4'hA);
    assign key_enter_s  = kif.key_valid && (kif.key_code == 4'hB);
    assign fail_inc_s   = fail_cnt_r + 3'd1;
    // Expiry fires on the cycle the count would reach zero, so the output holds exactly N cycles
    assign timer_last_s = (timer_r <= TIMER_ONE);

    // Digit/clear handling shared by code entry and password setting
    always_comb begin
        collect_buf_s = entry_buf_r;
        collect_cnt_s = digit_cnt_r;
        if (key_digit_s) begin
            if (digit_cnt_r < 3'd6) begin
                collect_buf_s = shift_digit(entry_buf_r, kif.key_code);
                collect_cnt_s = digit_cnt_r + 3'd1;
            end else begin
                collect_cnt_s = digit_cnt_r;
            end
        end else if (key_clear_s) begin
            collect_buf_s = 24'h000000;
            collect_cnt_s = 3'd0;
        end else begin
            collect_cnt_s = digit_cnt_r;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s      = state_r;
        entry_buf_s  = entry_buf_r;
        digit_cnt_s  = digit_cnt_r;
        fail_cnt_s   = fail_cnt_r;
        timer_s      = timer_r;
        match_s      = match_r;
        unlocked_s   = unlocked_r;
        err_start_s  = 1'b0;
        locked_out_s = locked_out_r;
`ifdef PWD_CHANGE_EN
        pwd_next_s   = pwd_r;
`endif
        case (state_r)
            ST_ENTRY: begin
                if (key_enter_s) begin
                    match_s     = (digit_cnt_r == 3'd6) && (entry_buf_r == cur_pwd_s);
                    err_start_s = ~match_s;
                    state_s     = ST_CHECK;
                end else begin
                    entry_buf_s = collect_buf_s;
                    digit_cnt_s = collect_cnt_s;
                end
            end
            ST_CHECK: begin
                entry_buf_s = 24'h000000;
                digit_cnt_s = 3'd0;
                if (match_r) begin
                    unlocked_s = 1'b1;
                    fail_cnt_s = 3'd0;
                    timer_s    = UNLOCK_LOAD;
                    state_s    = ST_OPEN;
                end else if (fail_inc_s == MAX_FAIL_C) begin
                    fail_cnt_s   = fail_inc_s;
                    locked_out_s = 1'b1;
                    timer_s      = LOCKOUT_LOAD;
                    state_s      = ST_LOCKOUT;
                end else begin
                    fail_cnt_s = fail_inc_s;
                    state_s    = ST_ENTRY;
                end
            end
            ST_OPEN: begin
                if (timer_last_s || key_enter_s) begin
                    unlocked_s = 1'b0;
                    timer_s    = TIMER_ZERO;
                    state_s    = ST_ENTRY;
`ifdef PWD_CHANGE_EN
                end else if (key_set_s) begin
                    entry_buf_s = 24'h000000;
                    digit_cnt_s = 3'd0;
                    state_s     = ST_SET;
`endif
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            ST_LOCKOUT: begin
                if (timer_last_s) begin
                    locked_out_s = 1'b0;
                    fail_cnt_s   = 3'd0;
                    timer_s      = TIMER_ZERO;
                    state_s      = ST_ENTRY;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
`ifdef PWD_CHANGE_EN
            ST_SET: begin
                if (key_enter_s) begin
                    if (digit_cnt_r == 3'd6) begin
                        pwd_next_s = entry_buf_r;
                        timer_s    = UNLOCK_LOAD;
                    end else begin
                        err_start_s = 1'b1;
                    end
                    entry_buf_s = 24'h000000;
                    digit_cnt_s = 3'd0;
                    state_s     = ST_OPEN;
                end else begin
                    entry_buf_s = collect_buf_s;
                    digit_cnt_s = collect_cnt_s;
                end
            end
`endif
            default: begin
                state_s      = ST_ENTRY;
                entry_buf_s  = 24'h000000;
                digit_cnt_s  = 3'd0;
                unlocked_s   = 1'b0;
                locked_out_s = 1'b0;
                timer_s      = TIMER_ZERO;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_ENTRY;
            entry_buf_r  <= 24'h000000;
            digit_cnt_r  <= 3'd0;
            fail_cnt_r   <= 3'd0;
            timer_r      <= TIMER_ZERO;
            match_r      <= 1'b0;
            unlocked_r   <= 1'b0;
            err_start_r  <= 1'b0;
            locked_out_r <= 1'b0;
`ifdef PWD_CHANGE_EN
            pwd_r        <= DEFAULT_PWD;
`endif
        end else begin
            state_r      <= state_s;
            entry_buf_r  <= entry_buf_s;
            digit_cnt_r  <= digit_cnt_s;
            fail_cnt_r   <= fail_cnt_s;
            timer_r      <= timer_s;
            match_r      <= match_s;
            unlocked_r   <= unlocked_s;
            err_start_r  <= err_start_s;
            locked_out_r <= locked_out_s;
`ifdef PWD_CHANGE_EN
            pwd_r        <= pwd_next_s;
`endif
        end
    end

    assign kif.unlocked   = unlocked_r;
    assign kif.err_start  = err_start_r;
    assign kif.locked_out = locked_out_r;
    assign kif.digit_cnt  = digit_cnt_r;
    assign kif.fail_cnt   = fail_cnt_r;

endmodule

// File: tb/tb_code_verifier.sv
// Scoreboard bench for code_verifier: stimulus queues expected events and state probes,
// a negedge monitor pops and compares them.
module tb_code_verifier;

    localparam int UNLOCK  = 500;
    localparam int LOCKOUT = 1000;
    localparam int EV_ERR = 0, EV_URISE = 1, EV_UFALL = 2, EV_LRISE = 3, EV_LFALL = 4;
    localparam int PR_UNL = 0, PR_LOCK = 1, PR_DIG = 2, PR_FAIL = 3, PR_ERR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   done  = 1'b0;

    typedef struct {int kind; int cyc; int fc;} ev_t;
    typedef struct {int what; int cyc; int val; string name;} pr_t;
    ev_t ev_q[$];
    pr_t pr_q[$];

    code_verifier_if kif ();

    code_verifier #(
        .DEFAULT_PWD   (24'h123456),
        .MAX_FAIL      (3),
        .UNLOCK_CYCLES (UNLOCK),
        .LOCKOUT_CYCLES(LOCKOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kif  (kif)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic expect_ev(input int kind, input int at, input int fc);
        ev_q.push_back('{kind, at, fc});
    endtask

    task automatic probe(input int what, input int val, input string name);
        pr_q.push_back('{what, cyc, val, name});
    endtask

    task automatic press(input logic [3:0] c);
        kif.key_valid = 1'b1;
        kif.key_code  = c;
        @(posedge clk);
        #1;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
    endtask

    task automatic enter6(input logic [23:0] code);
        for (int i = 5; i >= 0; i--) press(code[i*4 +: 4]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) idle(1);
    endtask

    // Monitor: compares every observed output event and every due probe against the queues
    initial begin : monitor
        logic prev_u, prev_l;
        int   kinds[5];
        int   act;
        ev_t  e;
        pr_t  p;
        prev_u = 1'b0;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 5; k++) kinds[k] = 0;
            if (rst_n) begin
                kinds[EV_ERR]   = int'(kif.err_start);
                kinds[EV_URISE] = int'(kif.unlocked & ~prev_u);
                kinds[EV_UFALL] = int'(~kif.unlocked & prev_u);
                kinds[EV_LRISE] = int'(kif.locked_out & ~prev_l);
                kinds[EV_LFALL] = int'(~kif.locked_out & prev_l);
            end
            for (int k = 0; k < 5; k++) begin
                if (kinds[k] != 0) begin
                    tests++;
                    if (ev_q.size() == 0) begin
                        fails++;
                        $display("FAIL event: got kind %0d at cycle %0d, required no event", k, cyc);
                    end else begin
                        e = ev_q.pop_front();
                        if (e.kind != k || e.cyc != cyc || e.fc != int'(kif.fail_cnt)) begin
                            fails++;
                            $display("FAIL event: got kind %0d cycle %0d fail_cnt %0d, required kind %0d cycle %0d fail_cnt %0d",
                                     k, cyc, kif.fail_cnt, e.kind, e.cyc, e.fc);
                        end
                    end
                end
            end
            prev_u = kif.unlocked;
            prev_l = kif.locked_out;
            while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
                p = pr_q.pop_front();
                case (p.what)
                    PR_UNL:  act = int'(kif.unlocked);
                    PR_LOCK: act = int'(kif.locked_out);
                    PR_DIG:  act = int'(kif.digit_cnt);
                    PR_FAIL: act = int'(kif.fail_cnt);
                    default: act = int'(kif.err_start);
                endcase
                tests++;
                if (act != p.val) begin
                    fails++;
                    $display("FAIL %s: got %0d, required %0d (cycle %0d)", p.name, act, p.val, cyc);
                end
            end
            if (done || cyc > 20000) begin
                tests++;
                if (!done || ev_q.size() != 0) begin
                    fails++;
                    $display("FAIL end_of_run: done=%0d, %0d expected events never seen, required done=1 and 0 pending",
                             done, ev_q.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin : stimulus
        int s;
        int e;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        probe(PR_UNL, 0, "rst_unlocked");
        probe(PR_LOCK, 0, "rst_locked_out");
        probe(PR_ERR, 0, "rst_err_start");
        idle(1);
        rst_n = 1'b1;
        probe(PR_DIG, 0, "rst_digit_cnt");
        probe(PR_FAIL, 0, "rst_fail_cnt");
        idle(2);

        // 1: correct code opens for exactly UNLOCK cycles; digits ignored while open
        enter6(24'h123456);
        probe(PR_DIG, 6, "t1_digit_cnt");
        press(4'hB);
        s = cyc;
        expect_ev(EV_URISE, s + 1, 0);
        expect_ev(EV_UFALL, s + 1 + UNLOCK, 0);
        idle(5);
        press(4'h5);
        probe(PR_DIG, 0, "t1_open_digit_ignored");
        probe(PR_UNL, 1, "t1_unlocked");
        wait_until(s + UNLOCK + 5);

        // 2: one wrong code
        enter6(24'h123457);
        press(4'hB);
        s = cyc;
        expect_ev(EV_ERR, s, 0);
        idle(3);
        probe(PR_FAIL, 1, "t2_fail_cnt");
        probe(PR_DIG, 0, "t2_digit_cnt");
        probe(PR_UNL, 0, "t2_unlocked");

        // 3: two more wrong codes reach lockout; keys ignored through the expiry cycle
        enter6(24'h111111);
        press(4'hB);
        s = cyc;
        expect_ev(EV_ERR, s, 1);
        idle(2);
        enter6(24'h999999);
        press(4'hB);
        s = cyc;
        expect_ev(EV_ERR, s, 2);
        expect_ev(EV_LRISE, s + 1, 3);
        expect_ev(EV_LFALL, s + 1 + LOCKOUT, 0);
        idle(3);
        probe(PR_LOCK, 1, "t3_locked_out");
        probe(PR_FAIL, 3, "t3_fail_cnt");
        enter6(24'h123456);
        press(4'hB);
        idle(3);
        probe(PR_UNL, 0, "t3_lockout_code_ignored");
        probe(PR_DIG, 0, "t3_lockout_digits_ignored");
        wait_until(s + LOCKOUT);
        press(4'h9);
        probe(PR_LOCK, 0, "t3_lockout_over");
        probe(PR_DIG, 0, "t3_expiry_key_dropped");
        probe(PR_FAIL, 0, "t3_fail_cleared");
        enter6(24'h123456);
        press(4'hB);
        s = cyc;
        expect_ev(EV_URISE, s + 1, 0);
        idle(10);
        press(4'hB);
        e = cyc;
        expect_ev(EV_UFALL, e, 0);
        idle(2);

        // 4: short entry, then saturation with a seventh and eighth digit
        press(4'h1); press(4'h2); press(4'h3);
        press(4'hB);
        s = cyc;
        expect_ev(EV_ERR, s, 0);
        idle(2);
        probe(PR_FAIL, 1, "t4_short_fail_cnt");
        enter6(24'h912345);
        probe(PR_DIG, 6, "t4_six_digits");
        press(4'h6); press(4'h7);
        probe(PR_DIG, 6, "t4_saturated");
        press(4'hB);
        s = cyc;
        expect_ev(EV_ERR, s, 1);
        idle(2);
        probe(PR_FAIL, 2, "t4_fail_cnt");

        // 5: clear key, correct code, then asynchronous reset while open
        press(4'h1); press(4'h2);
        probe(PR_DIG, 2, "t5_partial");
        press(4'hA);
        probe(PR_DIG, 0, "t5_cleared");
        enter6(24'h123456);
        press(4'hB);
        s = cyc;
        expect_ev(EV_URISE, s + 1, 0);
        idle(10);
        probe(PR_FAIL, 0, "t5_fail_cleared_on_match");
        idle(1);
        rst_n = 1'b0;
        probe(PR_UNL, 0, "t5_async_reset_unlocked");
        idle(2);
        rst_n = 1'b1;
        probe(PR_DIG, 0, "t5_post_reset_digits");
        idle(2);

`ifdef PWD_CHANGE_EN
        // 6: change the password from the open state
        enter6(24'h123456);
        press(4'hB);
        s = cyc;
        expect_ev(EV_URISE, s + 1, 0);
        idle(3);
        press(4'hC);
        probe(PR_UNL, 1, "t6_unlocked_in_set");
        enter6(24'h654321);
        probe(PR_DIG, 6, "t6_set_digits");
        press(4'hB);
        e = cyc;
        expect_ev(EV_UFALL, e + UNLOCK, 0);
        idle(3);
        probe(PR_UNL, 1, "t6_back_open");
        wait_until(e + UNLOCK + 2);
        enter6(24'h123456);
        press(4'hB);
        s = cyc;
        expect_ev(EV_ERR, s, 0);
        idle(2);
        enter6(24'h654321);
        press(4'hB);
        s = cyc;
        expect_ev(EV_URISE, s + 1, 0);
        idle(3);
        press(4'hB);
        e = cyc;
        expect_ev(EV_UFALL, e, 0);
        idle(2);
`endif

        idle(2);
        done = 1'b1;
    end

endmodule
